reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares one 16-bit Register (in/load/clk/out) among NUM_REQ requesters.
//  Round-robin arbitration; drives in/load for one cycle, then reads back out to verify.
//  Each transaction ends in a one-cycle ack to the winner, with a mismatch flag.
//  Sits between CPU-side write sources (e.g. ALU, loader, debug port) and the shared A/D register.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  WIDTH      16   register data width
//  ERRW       8    width of saturating mismatch counter
// PORTS
//  clk        in   1                single clock, rising edge
//  reset      in   1                synchronous, active-high
//  req        in   NUM_REQ          per-requester write request, level, held until ack
//  wdata      in   NUM_REQ*WIDTH    lane i = wdata[i*WIDTH +: WIDTH]
//  gnt        out  NUM_REQ          one-hot grant, registered
//  ack        out  NUM_REQ          one-hot, one-cycle completion pulse
//  err        out  1                valid with ack: 1 = readback mismatch
//  busy       out  1                1 whenever state != IDLE
//  err_cnt    out  ERRW             saturating count of mismatches
//  reg_in     out  WIDTH            to Register.in
//  reg_load   out  1                to Register.load
//  reg_out    in   WIDTH            from Register.out
// BEHAVIOUR
//  Reset values: state=IDLE, ptr=0, gnt=0, ack=0, err=0, busy=0, err_cnt=0, reg_load=0, reg_in=0.
//  FSM states: IDLE -> WRITE -> VERIFY -> RESP -> IDLE. All outputs are registered.
//  IDLE: if |req, winner = first set bit searching ptr, ptr+1, ... (mod NUM_REQ).
//   At that edge: latch idx and data=wdata lane idx; gnt<=onehot(idx); go to WRITE.
//   If req==0: stay in IDLE.
//  WRITE (1 cycle): reg_load=1, reg_in=latched data. The Register captures on the edge ending WRITE.
//  VERIFY (1 cycle): reg_load=0, reg_in holds its value. Compare reg_out with latched data.
//   At the end of the cycle: err<=mismatch; err_cnt<=err_cnt+mismatch, saturating at all-ones.
//  RESP (1 cycle): ack[idx]=1 and err valid. gnt is still asserted.
//   At the end of the cycle: gnt<=0, ack<=0, ptr<=(idx+1) mod NUM_REQ; go to IDLE.
//  Latency: req seen in IDLE cycle T -> reg_load high T+1 -> ack at T+3. Throughput is 1 write per 4 cycles.
//  A requester must drop req in the cycle after ack.
//   A req still high in IDLE is a new request; it competes under the rotated ptr.
//  wdata and req changes after the latch edge are ignored until the next IDLE.
//  A req dropped mid-transaction does not abort it; the write and ack still complete.
//  Never more than one gnt or ack bit high. reg_load is high only in WRITE.
//  Reset mid-transaction: all outputs return to reset values at the next edge, and no ack is issued.
//   If reset is sampled at the edge ending WRITE, the Register still captures; the arbiter does not undo it.
//  err_cnt does not wrap; it clears only on reset.
// TESTING
//  1. Reset, req=0001, lane0=16'd2222 -> reg_load high 1 cycle, Register.out=2222, ack=0001 at T+3, err=0.
//  2. req=1111 held; requesters drop req after their ack -> grant order 0,1,2,3; ptr wraps to 0.
//   Each ack is exactly 4 cycles apart.
//  3. req=0110 with ptr=2 -> grant 2 first, then 1. req=1000 asserted during the 2's transaction -> order 2,3,1.
//  4. Force reg_out=16'hDEAD during VERIFY for data 16'h1234 -> err=1 with ack; err_cnt=1.
//   255 further forced mismatches -> err_cnt holds at 8'hFF.
//  5. Assert reset during VERIFY -> next cycle gnt=0, ack=0, busy=0, err_cnt=0, ptr=0.
//   The Register keeps the value written in WRITE.
//  6. Change lane0 from 16'h00AA to 16'h5555 during WRITE -> Register.out=16'h00AA, err=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : reg_write_arbiter
// Purpose  : Shares one external WIDTH-bit register (in/load/out) among
//            NUM_REQ write requesters. A round-robin arbiter picks a winner,
//            drives the register for one cycle, reads it back for
//            verification, then returns a one-cycle ack to the winner with a
//            readback-mismatch flag. Mismatches are counted in a saturating
//            counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk_i        in   1              clock, rising edge
//   reset_i      in   1              synchronous, active-high reset
//   req_i        in   NUM_REQ        level write requests, held until ack
//   wdata_i      in   NUM_REQ*WIDTH  write data, lane i = [i*WIDTH +: WIDTH]
//   gnt_o        out  NUM_REQ        one-hot grant (registered)
//   ack_o        out  NUM_REQ        one-hot, one-cycle completion pulse
//   err_o        out  1              readback mismatch, valid with ack_o
//   busy_o       out  1              transaction in progress
//   err_cnt_o    out  ERRW           saturating mismatch count
//   reg_in_o     out  WIDTH          to register data input
//   reg_load_o   out  1              to register load enable
//   reg_out_i    in   WIDTH          from register data output
//------------------------------------------------------------------------------
`default_nettype none

module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ERRW    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [ERRW-1:0]          err_cnt_o,
  output logic [WIDTH-1:0]         reg_in_o,
  output logic                     reg_load_o,
  input  logic [WIDTH-1:0]         reg_out_i
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDXW-1:0]     ptr_q;
  logic [IDXW-1:0]     idx_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                err_q;
  logic                busy_q;
  logic [ERRW-1:0]     err_cnt_q;
  logic [WIDTH-1:0]    reg_in_q;
  logic                reg_load_q;

  // Unpack the flat write-data bus into per-requester lanes.
  logic [WIDTH-1:0] lane_w [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_w[g] = wdata_i[g*WIDTH +: WIDTH];
  end

  // Round-robin search: first set request starting at ptr_q, wrapping.
  logic [IDXW-1:0]    win_idx_d;
  logic               win_vld_d;
  logic [IDXW-1:0]    probe_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [WIDTH-1:0]   win_data_d;

  always_comb begin
    win_idx_d = ptr_q;
    win_vld_d = 1'b0;
    probe_d   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe_d = IDXW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld_d && req_i[probe_d]) begin
        win_vld_d = 1'b1;
        win_idx_d = probe_d;
      end
    end
  end

  assign win_oh_d   = NUM_REQ'(1) << win_idx_d;
  assign win_data_d = lane_w[win_idx_d];

  // reg_in_q doubles as the latched write data: it holds through VERIFY.
  logic            mismatch_d;
  logic            cnt_sat_d;
  logic [IDXW-1:0] next_ptr_d;

  assign mismatch_d = (reg_out_i != reg_in_q);
  assign cnt_sat_d  = &err_cnt_q;
  assign next_ptr_d = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + IDXW'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_cnt_q  <= '0;
      reg_in_q   <= '0;
      reg_load_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            idx_q      <= win_idx_d;
            gnt_q      <= win_oh_d;
            reg_in_q   <= win_data_d;
            reg_load_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The register captures reg_in_q on this edge.
          reg_load_q <= 1'b0;
          state_q    <= ST_VERIFY;
        end
        ST_VERIFY: begin
          err_q <= mismatch_d;
          if (mismatch_d && !cnt_sat_d) begin
            err_cnt_q <= err_cnt_q + ERRW'(1);
          end
          // The grant vector is already onehot(idx), so it is the ack pattern.
          ack_q   <= gnt_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= next_ptr_d;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign err_cnt_o  = err_cnt_q;
  assign reg_in_o   = reg_in_q;
  assign reg_load_o = reg_load_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter. Provides a behavioural
//            16-bit register, a transaction-level reference model checked on
//            every cycle, and directed scenarios with literal expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int E = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt, ack;
  logic           err, busy, reg_load;
  logic [E-1:0]   err_cnt;
  logic [W-1:0]   reg_in, reg_out;

  // The shared register, with an enable that forces a corrupted readback.
  logic [W-1:0] reg_q = '0;
  logic         force_en = 1'b0;
  assign reg_out = force_en ? 16'hDEAD : reg_q;

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_load) reg_q <= reg_in;

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .ERRW(E)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .wdata_i(wdata),
    .gnt_o(gnt), .ack_o(ack), .err_o(err), .busy_o(busy),
    .err_cnt_o(err_cnt), .reg_in_o(reg_in), .reg_load_o(reg_load),
    .reg_out_i(reg_out)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = r >> ((p + k) % N);
      if (s[0]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] w, input int i);
    logic [N*W-1:0] s;
    s = w >> (i * W);
    return s[W-1:0];
  endfunction

  int           mcyc = 0;
  int           t0 = 0;
  bit           open = 0;
  int           m_ptr = 0;
  int           m_idx = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_data = '0;
  logic         mm = 1'b0;
  logic [N-1:0] e_gnt = '0, e_ack = '0;
  logic         e_err = 1'b0, e_busy = 1'b0, e_load = 1'b0;
  logic [W-1:0] e_in = '0;

  // A transaction latched at edge t0 shows: WRITE after t0, VERIFY after
  // t0+1, RESP (ack) after t0+2, and is closed at edge t0+3.
  always @(posedge clk) begin
    mcyc++;
    if (reset) begin
      open = 0; m_ptr = 0; m_cnt = 0; e_in = '0;
    end else if (open) begin
      if (mcyc - t0 == 2) begin
        mm = (reg_out !== m_data);
        if (mm && m_cnt < (1 << E) - 1) m_cnt++;
      end else if (mcyc - t0 == 3) begin
        open = 0;
        m_ptr = (m_idx + 1) % N;
      end
    end else if (req != '0) begin
      m_idx = rr_pick(req, m_ptr);
      m_data = lane(wdata, m_idx);
      e_in = m_data;
      t0 = mcyc;
      open = 1;
    end
    if (open) begin
      e_gnt  = N'(1) << m_idx;
      e_busy = 1'b1;
      e_load = (mcyc == t0);
      e_ack  = (mcyc - t0 == 2) ? e_gnt : '0;
      e_err  = (mcyc - t0 == 2) ? mm : 1'b0;
    end else begin
      e_gnt = '0; e_ack = '0; e_busy = 1'b0; e_load = 1'b0; e_err = 1'b0;
    end
  end

  logic [N-1:0] last_ack = '0;

  always @(negedge clk) begin
    last_ack = ack;
    n_chk++;
    if (gnt === e_gnt && ack === e_ack && busy === e_busy && reg_load === e_load &&
        err_cnt === E'(m_cnt) && reg_in === e_in && (e_ack == '0 || err === e_err))
      n_pass++;
    else
      $display("FAIL model cyc%0d: gnt=%b/%b ack=%b/%b busy=%b/%b load=%b/%b cnt=%0d/%0d in=%h/%h err=%b/%b (got/expected)",
               mcyc, gnt, e_gnt, ack, e_ack, busy, e_busy, reg_load, e_load,
               err_cnt, m_cnt, reg_in, e_in, err, e_err);
  end

  // ---------------- stimulus helpers ----------------
  // Advance one cycle; a requester that was acked drops its request.
  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~last_ack;
  endtask

  // Returns at the negedge of the ack cycle; lat = cycles advanced.
  task automatic wait_ack(output int lat, output logic [N-1:0] a);
    lat = 0;
    a = '0;
    while (lat < 12) begin
      @(negedge clk);
      if (ack != '0) begin
        a = ack;
        return;
      end
      step();
      lat++;
    end
    n_chk++;
    $display("FAIL ack_timeout: no ack after %0d cycles, expected one", lat);
  endtask

  int           lat;
  int           prev_cyc;
  logic [N-1:0] a;
  logic [N-1:0] exp_order [3] = '{4'b0100, 4'b1000, 4'b0010};

  initial begin
    // Reset state
    step(); step();
    chk("rst_gnt_ack", {gnt, ack}, '0);
    chk("rst_flags", {err, busy, reg_load}, '0);
    chk("rst_cnt_in", {err_cnt, reg_in}, '0);
    reset = 1'b0;

    // 1: single write, latency and readback
    wdata[15:0] = 16'd2222;
    req = 4'b0001;
    wait_ack(lat, a);
    chk("t1_latency", lat, 3);
    chk("t1_ack", a, 4'b0001);
    chk("t1_err", err, 1'b0);
    chk("t1_reg", reg_q, 16'd2222);
    step();

    // 2: all requesting, rotation 0..3 with 4-cycle spacing
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(16'h1000 + i);
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_ack(lat, a);
      chk("t2_order", a, N'(1) << i);
      if (i > 0) chk("t2_spacing", mcyc - prev_cyc, 4);
      prev_cyc = mcyc;
      step();
    end
    req = 4'b0011;
    wait_ack(lat, a);
    chk("t2_ptr_wrap", a, 4'b0001);
    step();
    wait_ack(lat, a);
    chk("t2_second", a, 4'b0010);
    step();

    // 3: ptr=2, req 0110, then requester 3 joins mid-transaction
    req = 4'b0110;
    step();
    req[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(lat, a);
      chk("t3_order", a, exp_order[i]);
      step();
    end

    // 4: forced readback mismatches, counter saturation
    force_en = 1'b1;
    wdata[15:0] = 16'h1234;
    req = 4'b0001;
    wait_ack(lat, a);
    chk("t4_err", err, 1'b1);
    chk("t4_cnt1", err_cnt, 8'd1);
    step();
    for (int i = 0; i < 255; i++) begin
      req = 4'b0001;
      wait_ack(lat, a);
      step();
    end
    chk("t4_cnt_sat", err_cnt, 8'hFF);
    req = 4'b0001;
    wait_ack(lat, a);
    chk("t4_cnt_hold", err_cnt, 8'hFF);
    chk("t4_err_again", err, 1'b1);
    step();
    force_en = 1'b0;

    // 5: reset asserted during VERIFY
    wdata[15:0] = 16'h0F0F;
    req = 4'b0001;
    step();          // WRITE
    step();          // VERIFY
    reset = 1'b1;
    req = '0;
    step();
    chk("t5_gnt_ack", {gnt, ack}, '0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_cnt", err_cnt, 8'd0);
    chk("t5_reg_kept", reg_q, 16'h0F0F);
    reset = 1'b0;
    repeat (3) step();
    req = 4'b0011;
    wait_ack(lat, a);
    chk("t5_ptr_reset", a, 4'b0001);
    step();
    req = '0;
    step();
    step();

    // 6: lane data changed during WRITE is ignored
    wdata[15:0] = 16'h00AA;
    req = 4'b0001;
    step();          // WRITE
    wdata[15:0] = 16'h5555;
    wait_ack(lat, a);
    chk("t6_reg", reg_q, 16'h00AA);
    chk("t6_err", err, 1'b0);
    step();

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
